// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, keyboard command constants and parity helper for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - two-flop synchronizer with falling-edge detect for one idle-high PS/2 line
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Lines idle high, so reset to 1 to avoid a false edge when reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter driving open-drain clock/data enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CYC_PER_US  = CLK_FREQ / 1_000_000;
    localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
    localparam int INH_W       = $clog2(INHIBIT_CYC) + 1;
    localparam int TO_W        = $clog2(TIMEOUT_CYC) + 1;
    localparam int BIT_W       = $clog2(8) + 1;

    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [BIT_W-1:0] BITS_SENT = BIT_W'(8);

    logic clk_sync, clk_fall, data_sync, unused_data_fall;

    ps2_sync u_clk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_clk_i),
        .dout (clk_sync),
        .fall (clk_fall)
    );

    ps2_sync u_data_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_data_i),
        .dout (data_sync),
        .fall (unused_data_fall)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             cur_bit_q, cur_bit_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            cur_bit_q <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            cur_bit_q <= cur_bit_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            tx_done_q <= tx_done_d;
            tx_err_q  <= tx_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        cur_bit_d = cur_bit_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        tx_done_d = 1'b0;
        tx_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                inh_cnt_d = '0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = odd_parity(tx_data);
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    inh_cnt_d = '0;
                    state_d   = RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            RTS: begin
                if (clk_fall) begin
                    cur_bit_d = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = BIT_W'(1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    if (bit_cnt_q == BITS_SENT) begin
                        cur_bit_d = parity_q;
                        state_d   = PARITY;
                    end else begin
                        cur_bit_d = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    if (!data_sync) begin
                        state_d = ACK;
                    end else begin
                        tx_err_d = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end
            end
            ACK: begin
                if (clk_sync && data_sync) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Device-clocked phases abort if the keyboard stops clocking; this overrides any ACK completion.
        if (state_q inside {RTS, DATA, PARITY, STOP, ACK}) begin
            if (clk_fall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                to_cnt_d  = '0;
                tx_done_d = 1'b0;
                tx_err_d  = 1'b1;
                state_d   = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_ready    = (state_q == IDLE);
        case (state_q)
            INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (inh_cnt_q == INH_LAST);
            end
            RTS:          ps2_data_oe = 1'b1;
            DATA, PARITY: ps2_data_oe = ~cur_bit_q;
            default:      ps2_data_oe = 1'b0;
        endcase
    end

    assign tx_done = tx_done_q;
    assign tx_err  = tx_err_q;

endmodule
